// File: rtl/rc4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_pkg                                                              |
// | Shared byte width and keystream drop/run state encoding.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rc4_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_DROP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rc4_stream_xor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_stream_xor_if                                                    |
// | Keystream, plaintext and ciphertext handshakes plus status outputs.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface rc4_stream_xor_if #(
    parameter int ADDR_W = 4
);
    import rc4_pkg::*;

    logic              flush;
    logic              ks_valid;
    logic [BYTE_W-1:0] ks_byte;
    logic              din_valid;
    logic [BYTE_W-1:0] din;
    logic              din_ready;
    logic              dout_valid;
    logic [BYTE_W-1:0] dout;
    logic              dout_ready;
    logic [ADDR_W:0]   fifo_level;
    logic              overflow;

    modport master (
        output flush, ks_valid, ks_byte, din_valid, din, dout_ready,
        input  din_ready, dout_valid, dout, fifo_level, overflow
    );

    modport slave (
        input  flush, ks_valid, ks_byte, din_valid, din, dout_ready,
        output din_ready, dout_valid, dout, fifo_level, overflow
    );

endinterface
`default_nettype wire

// File: rtl/rc4_ks_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_ks_fifo                                                          |
// | Synchronous keystream FIFO; a push into a full FIFO lands only when  |
// | a pop happens in the same cycle.                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rc4_ks_fifo
    import rc4_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush,
    input  wire logic              push,
    input  wire logic              pop,
    input  wire logic [BYTE_W-1:0] din,
    output logic      [BYTE_W-1:0] head,
    output logic      [ADDR_W:0]   level,
    output logic                   full
);

    localparam int LVL_W = ADDR_W + 1;

    logic [BYTE_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              empty;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count == LVL_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && !flush && (!full || rd_en);
    assign head  = mem[rd_ptr];
    assign level = count;

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rc4_stream_xor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rc4_stream_xor                                                       |
// | Buffers free-running RC4 keystream, optionally drops the first       |
// | DROP_N bytes, and XORs it onto a valid/ready plaintext stream.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rc4_stream_xor
    import rc4_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int DROP_N     = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    rc4_stream_xor_if.slave bus
);

    localparam state_t      RESET_STATE = (DROP_N == 0) ? ST_RUN : ST_DROP;
    localparam logic [15:0] DROP_LAST   = (DROP_N == 0) ? 16'd0 : 16'(DROP_N - 1);

    state_t            state;
    state_t            state_next;
    logic [15:0]       drop_cnt;
    logic [15:0]       drop_cnt_next;
    logic              ks_push;
    logic              din_ready;
    logic              fire;
    logic              full;
    logic [BYTE_W-1:0] head;
    logic [ADDR_W:0]   level;
    logic              dout_valid;
    logic [BYTE_W-1:0] dout_q;
    logic              overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RESET_STATE;
            drop_cnt <= '0;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        drop_cnt_next = drop_cnt;
        ks_push       = 1'b0;
        if (bus.flush) begin
            state_next    = RESET_STATE;
            drop_cnt_next = '0;
        end else begin
            case (state)
                ST_DROP: begin
                    if (bus.ks_valid) begin
                        drop_cnt_next = drop_cnt + 16'd1;
                        if (drop_cnt == DROP_LAST) begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN:  ks_push = bus.ks_valid;
                default: state_next = RESET_STATE;
            endcase
        end
    end

    // Ready looks only at registered occupancy, so a byte pushed this cycle
    // cannot be consumed until the next one.
    assign din_ready = !bus.flush && (level != '0) && (!dout_valid || bus.dout_ready);
    assign fire      = bus.din_valid && din_ready;

    rc4_ks_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .push  (ks_push),
        .pop   (fire),
        .din   (bus.ks_byte),
        .head  (head),
        .level (level),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_valid <= 1'b0;
            dout_q     <= '0;
            overflow   <= 1'b0;
        end else if (bus.flush) begin
            dout_valid <= 1'b0;
            dout_q     <= '0;
            overflow   <= 1'b0;
        end else begin
            if (fire) begin
                dout_valid <= 1'b1;
                dout_q     <= bus.din ^ head;
            end else if (bus.dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (ks_push && full && !fire) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.din_ready  = din_ready;
    assign bus.dout_valid = dout_valid;
    assign bus.dout       = dout_q;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow;

endmodule
`default_nettype wire

// File: tb/tb_rc4_stream_xor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rc4_stream_xor                                                    |
// | Queue-model bench for rc4_stream_xor (DROP_N=0 and DROP_N=3).        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rc4_stream_xor;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       ks_valid = 1'b0;
    logic [7:0] ks_byte = 8'h00;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dout_ready = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    logic       m_ovf;
    logic       m_dv;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    rc4_stream_xor_if #(.ADDR_W(4)) bus_a ();
    rc4_stream_xor_if #(.ADDR_W(4)) bus_b ();

    assign bus_a.flush      = flush;
    assign bus_a.ks_valid   = ks_valid;
    assign bus_a.ks_byte    = ks_byte;
    assign bus_a.din_valid  = din_valid;
    assign bus_a.din        = din;
    assign bus_a.dout_ready = dout_ready;
    assign bus_b.flush      = flush;
    assign bus_b.ks_valid   = ks_valid;
    assign bus_b.ks_byte    = ks_byte;
    assign bus_b.din_valid  = din_valid;
    assign bus_b.din        = din;
    assign bus_b.dout_ready = dout_ready;

    rc4_stream_xor #(.FIFO_DEPTH(DEPTH), .ADDR_W(4), .DROP_N(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    rc4_stream_xor #(.FIFO_DEPTH(DEPTH), .ADDR_W(4), .DROP_N(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_dv   = 1'b0;
        m_dout = 8'h00;
    endtask

    // One clock of stimulus on both DUTs; the queue model tracks the DROP_N=0 instance.
    task automatic tick(input logic f, input logic kv, input logic [7:0] kb,
                        input logic dv_in, input logic [7:0] d, input logic dr);
        logic exp_ready;
        logic fire;
        logic was_full;
        @(negedge clk);
        flush = f; ks_valid = kv; ks_byte = kb; din_valid = dv_in; din = d; dout_ready = dr;
        #1;
        exp_ready = !f && (mq.size() != 0) && (!m_dv || dr);
        tests++;
        if (bus_a.din_ready !== exp_ready) begin
            fails++;
            $display("FAIL din_ready @%0t: got %b expected %b", $time, bus_a.din_ready, exp_ready);
        end
        if (f) begin
            model_reset();
        end else begin
            was_full = (mq.size() == DEPTH);
            fire     = dv_in && exp_ready;
            if (fire) begin
                m_dout = d ^ mq.pop_front();
                m_dv   = 1'b1;
            end else if (m_dv && dr) begin
                m_dv = 1'b0;
            end
            if (kv) begin
                if (!was_full || fire) mq.push_back(kb);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus_a.dout_valid !== m_dv) begin
            fails++;
            $display("FAIL dout_valid @%0t: got %b expected %b", $time, bus_a.dout_valid, m_dv);
        end
        tests++;
        if (bus_a.dout !== m_dout) begin
            fails++;
            $display("FAIL dout @%0t: got %h expected %h", $time, bus_a.dout, m_dout);
        end
        tests++;
        if (bus_a.fifo_level !== 5'(mq.size())) begin
            fails++;
            $display("FAIL fifo_level @%0t: got %0d expected %0d", $time, bus_a.fifo_level, mq.size());
        end
        tests++;
        if (bus_a.overflow !== m_ovf) begin
            fails++;
            $display("FAIL overflow @%0t: got %b expected %b", $time, bus_a.overflow, m_ovf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if ({bus_a.dout_valid, bus_a.dout, bus_a.fifo_level, bus_a.overflow, bus_a.din_ready} !== 16'h0) begin
            fails++;
            $display("FAIL reset_a: got dv=%b dout=%h lvl=%0d ovf=%b rdy=%b expected all 0",
                     bus_a.dout_valid, bus_a.dout, bus_a.fifo_level, bus_a.overflow, bus_a.din_ready);
        end
        tests++;
        if ({bus_b.dout_valid, bus_b.dout, bus_b.fifo_level, bus_b.overflow, bus_b.din_ready} !== 16'h0) begin
            fails++;
            $display("FAIL reset_b: got dv=%b dout=%h lvl=%0d ovf=%b rdy=%b expected all 0",
                     bus_b.dout_valid, bus_b.dout, bus_b.fifo_level, bus_b.overflow, bus_b.din_ready);
        end
    endtask

    task automatic test_known_vector();
        logic [7:0] ks [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
        logic [7:0] pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        logic [7:0] ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, ks[i], 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1, pt[i], 1'b1);
            tests++;
            if (!bus_a.dout_valid || bus_a.dout !== ct[i]) begin
                fails++;
                $display("FAIL known_vector[%0d]: got v=%b %h expected v=1 %h", i, bus_a.dout_valid, bus_a.dout, ct[i]);
            end
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tests++;
        if (bus_a.fifo_level !== 5'd0 || bus_a.overflow !== 1'b0) begin
            fails++;
            $display("FAIL known_vector_end: got lvl=%0d ovf=%b expected 0 0", bus_a.fifo_level, bus_a.overflow);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 8'h00, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
        held = bus_a.dout;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1, 8'(i), 1'b0);
            tests++;
            if (bus_a.dout !== held || bus_a.din_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold[%0d]: got dout=%h rdy=%b expected %h 0", i, bus_a.dout, bus_a.din_ready, held);
            end
        end
        tests++;
        if (bus_a.fifo_level !== 5'd3 || held !== (8'h5A ^ 8'hC0)) begin
            fails++;
            $display("FAIL backpressure_level: got lvl=%0d dout=%h expected 3 %h", bus_a.fifo_level, held, 8'h5A ^ 8'hC0);
        end
        for (int i = 1; i < 4; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
            tests++;
            if (bus_a.dout !== 8'(8'hC0 + i) || !bus_a.dout_valid) begin
                fails++;
                $display("FAIL backpressure_release[%0d]: got %h expected %h", i, bus_a.dout, 8'(8'hC0 + i));
            end
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_overflow();
        tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 17; i++) tick(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b1);
        tests++;
        if (bus_a.fifo_level !== 5'd16 || bus_a.overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_flag: got lvl=%0d ovf=%b expected 16 1", bus_a.fifo_level, bus_a.overflow);
        end
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
            tests++;
            if (bus_a.dout !== 8'(i)) begin
                fails++;
                $display("FAIL overflow_drain[%0d]: got %h expected %h", i, bus_a.dout, 8'(i));
            end
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
        tests++;
        if (bus_a.dout_valid !== 1'b0 || bus_a.overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_lost: got dv=%b ovf=%b expected 0 1", bus_a.dout_valid, bus_a.overflow);
        end
    endtask

    task automatic test_full_simultaneous();
        tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 8'h00, 1'b1);
        tick(1'b0, 1'b1, 8'hAA, 1'b1, 8'h00, 1'b1);
        tests++;
        if (bus_a.fifo_level !== 5'd16 || bus_a.overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_simul: got lvl=%0d ovf=%b expected 16 0", bus_a.fifo_level, bus_a.overflow);
        end
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
        tests++;
        if (bus_a.dout !== 8'hAA) begin
            fails++;
            $display("FAIL full_simul_tail: got %h expected aa", bus_a.dout);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_drop();
        logic [7:0] exp_b [2] = '{8'h44, 8'h55};
        int peak;
        peak = 0;
        tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b0, 1'b1, 8'(8'h11 * i), 1'b0, 8'h00, 1'b1);
            if (int'(bus_b.fifo_level) > peak) peak = int'(bus_b.fifo_level);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
            tests++;
            if (!bus_b.dout_valid || bus_b.dout !== exp_b[i]) begin
                fails++;
                $display("FAIL drop_dout[%0d]: got v=%b %h expected v=1 %h", i, bus_b.dout_valid, bus_b.dout, exp_b[i]);
            end
        end
        tests++;
        if (peak != 2) begin
            fails++;
            $display("FAIL drop_peak: got %0d expected 2", peak);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) tick(1'b0, 1'b1, 8'(8'h11 * i), 1'b0, 8'h00, 1'b1);
        tests++;
        if (bus_b.fifo_level !== 5'd1 || bus_b.din_ready !== 1'b1) begin
            fails++;
            $display("FAIL drop_restart: got lvl=%0d rdy=%b expected 1 1", bus_b.fifo_level, bus_b.din_ready);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 17; i++) tick(1'b0, 1'b1, 8'(i), 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b0);
        tests++;
        if (!bus_a.dout_valid || bus_a.overflow !== 1'b1 || bus_a.fifo_level !== 5'd15) begin
            fails++;
            $display("FAIL flush_pre: got dv=%b ovf=%b lvl=%0d expected 1 1 15", bus_a.dout_valid, bus_a.overflow, bus_a.fifo_level);
        end
        tick(1'b1, 1'b1, 8'h77, 1'b1, 8'h01, 1'b1);
        tests++;
        if ({bus_a.dout_valid, bus_a.dout, bus_a.fifo_level, bus_a.overflow} !== 15'h0) begin
            fails++;
            $display("FAIL flush_post: got dv=%b dout=%h lvl=%0d ovf=%b expected all 0",
                     bus_a.dout_valid, bus_a.dout, bus_a.fifo_level, bus_a.overflow);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'(8'h90 + i), 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 8'h0F, 1'b0);
        @(negedge clk);
        din_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({bus_a.dout_valid, bus_a.dout, bus_a.fifo_level, bus_a.overflow, bus_a.din_ready} !== 16'h0) begin
            fails++;
            $display("FAIL async_reset: got dv=%b dout=%h lvl=%0d ovf=%b rdy=%b expected all 0",
                     bus_a.dout_valid, bus_a.dout, bus_a.fifo_level, bus_a.overflow, bus_a.din_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
                 ($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_known_vector();
        test_backpressure();
        test_overflow();
        test_full_simultaneous();
        test_drop();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rc4_stream_xor.md
Name: rc4_stream_xor

Overview:
- Downstream consumer of the rc4 PRGA core. Takes the free-running keystream (rc4 `K` qualified by `output_ready`) and buffers it in a small FIFO.
- Optionally discards the first DROP_N keystream bytes (RC4-drop[N]).
- XORs buffered keystream bytes one-for-one with a valid/ready plaintext stream and emits ciphertext on a registered valid/ready output.
- The rc4 core cannot be stalled, so FIFO overflow is detected and flagged, never back-pressured.

Parameters:
- FIFO_DEPTH, 16, keystream FIFO entries; power of two, at least 2.
- ADDR_W, 4, log2(FIFO_DEPTH).
- DROP_N, 0, keystream bytes discarded after reset or flush; 0 to 65535.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear: empties FIFO, clears output and overflow, restarts drop.
- ks_valid  input  1  keystream byte valid (rc4 output_ready).
- ks_byte  input  8  keystream byte (rc4 K).
- din_valid  input  1  plaintext byte valid.
- din  input  8  plaintext byte.
- din_ready  output  1  plaintext byte accepted this cycle when high with din_valid.
- dout_valid  output  1  ciphertext byte valid.
- dout  output  8  ciphertext byte.
- dout_ready  input  1  downstream accepts dout.
- fifo_level  output  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky; a keystream byte was lost.

Behaviour:
- Reset (rst low, asynchronous):
  - state=DROP, or RUN if DROP_N=0; drop counter=0.
  - FIFO pointers=0, fifo_level=0.
  - dout_valid=0, dout=0, overflow=0.
  - din_ready=0, because it is derived from the empty FIFO.
- State machine:
  - DROP: every ks_valid cycle increments the drop counter and the byte is discarded. On the cycle the counter reaches DROP_N-1 with ks_valid, go to RUN; that byte is also dropped.
  - RUN: ks_valid pushes ks_byte into the FIFO. RUN is left only by reset or flush.
- Push rule in RUN:
  - Accept when not full, or when full and a pop occurs in the same cycle.
  - If full with no pop: byte discarded, overflow set to 1 on the next edge, FIFO unchanged.
- Pop / XOR rule:
  - din_ready = (fifo_level != 0) && (!dout_valid || dout_ready). This is combinational from registered state and does not depend on the current-cycle push.
  - Fire = din_valid && din_ready. On fire: dout <= din ^ fifo_head, dout_valid <= 1, FIFO pops.
  - Latency is 1 clock from fire to dout_valid.
- Output hold:
  - dout_valid && !dout_ready: dout and dout_valid hold, no pop.
  - dout_valid && dout_ready && no fire: dout_valid <= 0.
  - Full throughput of 1 byte/clk when FIFO is non-empty and dout_ready is held high.
- Empty FIFO with a same-cycle push and din_valid: no bypass. din_ready stays 0; the byte becomes poppable next cycle.
- fifo_level:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Pointers wrap modulo FIFO_DEPTH.
- flush (synchronous, highest priority after reset):
  - Same end state as reset on the next edge.
  - A ks_valid or din_valid in the flush cycle is ignored; din_ready is forced to 0 during flush.
- overflow clears only on reset or flush.
- Reset or flush mid-stream: buffered keystream is discarded. Upstream rc4 must be restarted by the system to stay key-aligned; this block does not resync.

Decomposition:
- Shared package rc4_pkg: byte width constant (8) and the DROP/RUN state encoding.
- One sub-module, rc4_ks_fifo: synchronous FIFO with push, pop, head, level and full; simultaneous push/pop legal when full. The XOR, handshake and drop FSM stay in rc4_stream_xor.

Test Plan:
- Known vector, DROP_N=0: push ks EB 9F 77 81 B7 34 CA 72 A7, then send "Plaintext" (50 6C 61 69 6E 74 65 78 74) with dout_ready=1 -> dout BB F3 16 E8 D9 40 AF 0A D3 on consecutive cycles; overflow=0; final fifo_level=0.
- Drop, DROP_N=3: push ks 11 22 33 44 55, then din 00 00 -> dout 44 55; fifo_level peaks at 2.
- Backpressure: 4 ks bytes buffered, din_valid=1, dout_ready held 0 for 5 cycles -> exactly one byte fires; dout is stable for the 5 cycles; din_ready=0; fifo_level=3. Release dout_ready -> remaining 3 bytes at 1/clk.
- Overflow, FIFO_DEPTH=16: 17 ks bytes 00..10 with no din -> fifo_level=16, overflow=1. Subsequent 16 din=00 -> dout 00..0F, byte 10 is absent.
- Full plus simultaneous: FIFO full, same cycle ks_valid and fire -> push accepted, fifo_level stays 16, overflow stays 0.
- Flush/reset: assert flush with 5 bytes buffered and dout_valid=1 -> next cycle fifo_level=0, dout_valid=0, overflow=0, drop counter restarts. Asynchronous rst low mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
